c_bus_write_arbiter: RTL and testbench

C_BUS_WRITE_ARBITER -- requirements
Module: c_bus_write_arbiter

---
 rtl/c_bus_write_arbiter.sv | 134 +++++++++++++
 tb/tb_c_bus_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/c_bus_write_arbiter.sv
// Round-robin arbiter that grants one of NREQ requesters a single-cycle write
// onto the shared C_bus and pulses the one-hot GPR load enable for it.
module c_bus_write_arbiter #(
    parameter int DW    = 24,
    parameter int NREQ  = 3,
    parameter int NDEST = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_dest,
    input  logic [DW*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        C_bus,
    output logic [NDEST-1:0]     load,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    // First requesting index in the order p, p+1, ... modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          hit;
        int            idx;
        w   = '0;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!hit && r[idx]) begin
                hit = 1'b1;
                w   = PW'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [NDEST-1:0] dest_decode(input logic [2:0] code);
        logic [NDEST-1:0] oh;
        for (int i = 0; i < NDEST; i++) begin
            oh[i] = (code == 3'(i));
        end
        return oh;
    endfunction

    function automatic logic dest_invalid(input logic [2:0] code);
        return (int'(code) >= NDEST);
    endfunction

    logic [0:0]       state_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    win_r;
    logic [NREQ-1:0]  ack_r;
    logic [DW-1:0]    c_bus_r;
    logic [NDEST-1:0] load_r;
    logic             busy_r;
    logic             err_r;

    logic [PW-1:0]    win_s;
    logic [2:0]       win_dest_s;
    logic [DW-1:0]    win_data_s;
    logic [PW-1:0]    ptr_next_s;

    // Winner selection and the operands it would latch this cycle.
    always_comb begin
        win_s      = rr_pick(req, ptr_r);
        win_dest_s = req_dest[int'(win_s)*3 +: 3];
        win_data_s = req_data[int'(win_s)*DW +: DW];
        if (win_r == PW'(NREQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_r + PW'(1);
        end
    end

    // Two-state write FSM; grant outputs are captured at the granting edge so the
    // WRITE cycle sees only registered values, immune to requester-side changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            ack_r   <= '0;
            c_bus_r <= '0;
            load_r  <= '0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        state_r <= WRITE;
                        win_r   <= win_s;
                        c_bus_r <= win_data_s;
                        load_r  <= dest_decode(win_dest_s);
                        err_r   <= dest_invalid(win_dest_s);
                        ack_r   <= NREQ'(1) << win_s;
                        busy_r  <= 1'b1;
                    end else begin
                        load_r  <= '0;
                        ack_r   <= '0;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r <= IDLE;
                    ptr_r   <= ptr_next_s;
                    load_r  <= '0;
                    ack_r   <= '0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    load_r  <= '0;
                    ack_r   <= '0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ack   = ack_r;
    assign C_bus = c_bus_r;
    assign load  = load_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_c_bus_write_arbiter.sv
// Bench for c_bus_write_arbiter: directed scenarios plus randomized handshaking
// requesters, all compared against a cycle-level reference model.
module tb_c_bus_write_arbiter;

    localparam int DW    = 24;
    localparam int NREQ  = 3;
    localparam int NDEST = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_dest;
    logic [DW*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     C_bus;
    logic [NDEST-1:0]  load;
    logic              busy;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    c_bus_write_arbiter #(.DW(DW), .NREQ(NREQ), .NDEST(NDEST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dest(req_dest), .req_data(req_data),
        .ack(ack), .C_bus(C_bus), .load(load), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who wins, given the requests and the rotating priority.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NDEST-1:0] exp_load(input logic [2:0] code);
        logic [NDEST-1:0] one;
        one = 6'b000001;
        return (code < 3'd6) ? (one << code) : 6'b000000;
    endfunction

    bit               m_write;
    int               m_ptr;
    int               m_win;
    logic [NREQ-1:0]  e_ack;
    logic [DW-1:0]    e_cbus;
    logic [NDEST-1:0] e_load;
    logic             e_busy;
    logic             e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_write <= 1'b0; m_ptr <= 0; m_win <= 0;
            e_ack <= '0; e_cbus <= '0; e_load <= '0; e_busy <= 1'b0; e_err <= 1'b0;
        end else if (m_write) begin
            m_write <= 1'b0;
            m_ptr   <= (m_win + 1) % NREQ;
            e_ack <= '0; e_load <= '0; e_busy <= 1'b0; e_err <= 1'b0;
        end else if (req != '0) begin
            m_write <= 1'b1;
            m_win   <= pick(req, m_ptr);
            e_ack   <= 3'b001 << pick(req, m_ptr);
            e_cbus  <= req_data[DW*pick(req, m_ptr) +: DW];
            e_load  <= exp_load(req_dest[3*pick(req, m_ptr) +: 3]);
            e_err   <= (req_dest[3*pick(req, m_ptr) +: 3] > 3'd5);
            e_busy  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack", 32'(ack), 32'(e_ack));
            chk("cbus", 32'(C_bus), 32'(e_cbus));
            chk("load", 32'(load), 32'(e_load));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("err", 32'(err), 32'(e_err));
            chk("load_onehot", 32'($countones(load) <= 1), 32'd1);
        end
    end

    logic [NREQ-1:0] rr_tbl [8];

    initial begin
        rst_n = 1'b0; req = '0; req_dest = '0; req_data = '0;
        rr_tbl = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        repeat (2) @(negedge clk);
        chk("rst_cbus", 32'(C_bus), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Single request to AC.
        @(negedge clk);
        req = 3'b001; req_dest[2:0] = 3'd5; req_data[23:0] = 24'hABCDEF;
        @(negedge clk);
        chk("single_load", 32'(load), 32'h20);
        chk("single_cbus", 32'(C_bus), 32'hABCDEF);
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        req = 3'b000;
        @(negedge clk);
        chk("idle_ack", 32'(ack), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_cbus_hold", 32'(C_bus), 32'hABCDEF);

        // Pointer at 1 with requesters 0 and 2: 2 wins first.
        req = 3'b101; req_dest[2:0] = 3'd0; req_dest[8:6] = 3'd1;
        req_data[23:0] = 24'h111111; req_data[71:48] = 24'h333333;
        @(negedge clk);
        chk("ptr_first_ack", 32'(ack), 32'h4);
        chk("ptr_first_cbus", 32'(C_bus), 32'h333333);
        req = 3'b001;
        @(negedge clk);
        chk("ptr_gap_ack", 32'(ack), 32'h0);
        @(negedge clk);
        chk("ptr_second_ack", 32'(ack), 32'h1);
        req = 3'b000;
        @(negedge clk);

        // Invalid destination, and data changes during WRITE.
        req = 3'b010; req_dest[5:3] = 3'd7; req_data[47:24] = 24'h123456;
        @(negedge clk);
        chk("inv_ack", 32'(ack), 32'h2);
        chk("inv_err", 32'(err), 32'h1);
        chk("inv_load", 32'(load), 32'h0);
        req_data[47:24] = 24'h654321; req_dest[5:3] = 3'd2;
        #3;
        chk("stable_cbus", 32'(C_bus), 32'h123456);
        chk("stable_load", 32'(load), 32'h0);
        req = 3'b000;
        @(negedge clk);

        // Reset in the middle of a WRITE cycle.
        req = 3'b001; req_dest[2:0] = 3'd0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_load", 32'(load), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all three requesters continuously re-requesting.
        req = 3'b111; req_dest = {3'd2, 3'd1, 3'd0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_ack", 32'(ack), 32'(rr_tbl[c]));
            req = ~rr_tbl[c];
        end
        req = 3'b000;
        @(negedge clk);

        // Randomized handshaking requesters.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i]) begin
                    req[i] = 1'b0;
                    req_dest[3*i +: 3] = 3'($urandom_range(0, 7));
                    req_data[DW*i +: DW] = DW'($urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_dest[3*i +: 3] = 3'($urandom_range(0, 7));
                    req_data[DW*i +: DW] = DW'($urandom);
                end
            end
        end
        req = 3'b000;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
